// File: rtl/spi_peripheral_if.sv
// SPI pin bundle between an external controller and the PWM register target.
// Write-only link: there is no CIPO line.
interface spi_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;

    modport master (output sclk, output copi, output ncs);
    modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only target holding the five PWM-stage control registers.
// SPI pins are synchronised into clk; 16-bit frames {rw, addr[6:0], data[7:0]}, MSB first.
module spi_peripheral #(
    parameter int unsigned MAX_ADDR    = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    spi_peripheral_if.slave spi,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    typedef enum logic [1:0] {StWaitIdle, StIdle, StShift, StCommit} state_t;

    // Top bit of the sclk/ncs chains is the previous-sample flop for edge detection.
    logic [SYNC_STAGES:0]   sclk_sr;
    logic [SYNC_STAGES:0]   ncs_sr;
    logic [SYNC_STAGES-1:0] copi_sr;

    logic sync_sclk, sync_copi, sync_ncs;
    logic sclk_rise, ncs_rise, ncs_fall;

    state_t      state_q, state_d;
    logic [15:0] shift_q;
    logic [4:0]  count_q;
    logic        clear_frame, shift_en, commit_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr <= '0;
            copi_sr <= '0;
            ncs_sr  <= '1;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-1:0], spi.sclk};
            copi_sr <= {copi_sr[SYNC_STAGES-2:0], spi.copi};
            ncs_sr  <= {ncs_sr[SYNC_STAGES-1:0], spi.ncs};
        end
    end

    assign sync_sclk = sclk_sr[SYNC_STAGES-1];
    assign sync_copi = copi_sr[SYNC_STAGES-1];
    assign sync_ncs  = ncs_sr[SYNC_STAGES-1];
    assign sclk_rise = sync_sclk & ~sclk_sr[SYNC_STAGES];
    assign ncs_rise  = sync_ncs & ~ncs_sr[SYNC_STAGES];
    assign ncs_fall  = ~sync_ncs & ncs_sr[SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StWaitIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitIdle: if (sync_ncs) state_d = StIdle;
            StIdle:     if (ncs_fall) state_d = StShift;
            StShift:    if (ncs_rise) state_d = StCommit;
            StCommit:   state_d = StIdle;
            default:    state_d = StWaitIdle;
        endcase
    end

    always_comb begin
        clear_frame  = (state_q == StIdle) && ncs_fall;
        shift_en     = (state_q == StShift) && sclk_rise;
        commit_valid = (state_q == StCommit) && (count_q == 5'd16) && shift_q[15] &&
                       (32'(shift_q[14:8]) <= MAX_ADDR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q         <= '0;
            count_q         <= '0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            wr_strobe       <= 1'b0;
        end else begin
            wr_strobe <= commit_valid;
            if (clear_frame) begin
                shift_q <= '0;
                count_q <= '0;
            end else if (shift_en) begin
                shift_q <= {shift_q[14:0], sync_copi};
                // Saturating at 17 keeps over-long frames distinguishable from 16-bit ones.
                if (count_q != 5'd17) count_q <= count_q + 5'd1;
            end
            if (commit_valid) begin
                case (shift_q[14:8])
                    7'd0:    en_reg_out_7_0  <= shift_q[7:0];
                    7'd1:    en_reg_out_15_8 <= shift_q[7:0];
                    7'd2:    en_reg_pwm_7_0  <= shift_q[7:0];
                    7'd3:    en_reg_pwm_15_8 <= shift_q[7:0];
                    7'd4:    pwm_duty_cycle  <= shift_q[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: bit-banged SPI frames with hand-computed register images.
module tb_spi_peripheral;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;

    spi_peripheral_if spi_bus ();

    spi_peripheral #(
        .MAX_ADDR   (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .spi            (spi_bus),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle),
        .wr_strobe      (wr_strobe)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt = 0;
    int strobe_cnt = 0;
    logic [7:0] obs [5];
    logic [7:0] exp_regs [5];

    assign obs[0] = en_reg_out_7_0;
    assign obs[1] = en_reg_out_15_8;
    assign obs[2] = en_reg_pwm_7_0;
    assign obs[3] = en_reg_pwm_15_8;
    assign obs[4] = pwm_duty_cycle;

    always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

    // SCLK half period is 5 clk, above the 3-clk minimum the synchroniser needs.
    task automatic spi_bits(input logic [15:0] word, input int first, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            spi_bus.copi = (first - i >= 0) ? word[first-i] : 1'b0;
            repeat (5) @(negedge clk);
            spi_bus.sclk = 1'b1;
            repeat (5) @(negedge clk);
            spi_bus.sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] word, input int nbits, input int gap);
        spi_bus.ncs = 1'b0;
        repeat (5) @(negedge clk);
        spi_bits(word, 15, nbits);
        repeat (5) @(negedge clk);
        spi_bus.ncs = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (20) @(negedge clk);
        for (int r = 0; r < 5; r++) begin
            chk_cnt++;
            if (obs[r] !== 8'h00) $display("FAIL reset_reg%0d got %h want 00", r, obs[r]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (strobe_cnt !== 0) $display("FAIL reset_strobe got %0d want 0", strobe_cnt);
        else pass_cnt++;
    endtask

    task automatic test_write();
        int base;
        int lat;
        base = strobe_cnt;
        lat = -1;
        spi_bus.ncs = 1'b0;
        repeat (5) @(negedge clk);
        spi_bits(16'h80F0, 15, 16);
        repeat (5) @(negedge clk);
        spi_bus.ncs = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (lat < 0 && en_reg_out_7_0 === 8'hF0) lat = c;
        end
        chk_cnt++;
        if (lat < 3 || lat > 5) $display("FAIL write_latency got %0d want 3..5", lat);
        else pass_cnt++;
        chk_cnt++;
        if (en_reg_out_7_0 !== 8'hF0) $display("FAIL write_reg0 got %h want F0", en_reg_out_7_0);
        else pass_cnt++;
        chk_cnt++;
        if (strobe_cnt - base !== 1) $display("FAIL write_strobe got %0d want 1", strobe_cnt - base);
        else pass_cnt++;
        send_frame(16'h8480, 16, 12);
        chk_cnt++;
        if (pwm_duty_cycle !== 8'h80) $display("FAIL write_duty got %h want 80", pwm_duty_cycle);
        else pass_cnt++;
        chk_cnt++;
        if (strobe_cnt - base !== 2) $display("FAIL write_strobe2 got %0d want 2", strobe_cnt - base);
        else pass_cnt++;
    endtask

    task automatic test_dropped();
        int base;
        base = strobe_cnt;
        send_frame(16'h00AA, 16, 12);
        send_frame(16'h85FF, 16, 12);
        exp_regs = '{8'hF0, 8'h00, 8'h00, 8'h00, 8'h80};
        for (int r = 0; r < 5; r++) begin
            chk_cnt++;
            if (obs[r] !== exp_regs[r])
                $display("FAIL drop_reg%0d got %h want %h", r, obs[r], exp_regs[r]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (strobe_cnt - base !== 0) $display("FAIL drop_strobe got %0d want 0", strobe_cnt - base);
        else pass_cnt++;
    endtask

    task automatic test_length();
        int base;
        base = strobe_cnt;
        send_frame(16'h82AB, 15, 12);
        send_frame(16'h82AB, 17, 12);
        chk_cnt++;
        if (en_reg_pwm_7_0 !== 8'h00) $display("FAIL len_reg2 got %h want 00", en_reg_pwm_7_0);
        else pass_cnt++;
        chk_cnt++;
        if (strobe_cnt - base !== 0) $display("FAIL len_strobe got %0d want 0", strobe_cnt - base);
        else pass_cnt++;
        send_frame(16'h82CC, 16, 12);
        chk_cnt++;
        if (en_reg_pwm_7_0 !== 8'hCC) $display("FAIL len_good got %h want CC", en_reg_pwm_7_0);
        else pass_cnt++;
        chk_cnt++;
        if (strobe_cnt - base !== 1) $display("FAIL len_strobe2 got %0d want 1", strobe_cnt - base);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        int base;
        spi_bus.ncs = 1'b0;
        repeat (5) @(negedge clk);
        spi_bits(16'h83A5, 15, 8);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = strobe_cnt;
        spi_bits(16'h83A5, 7, 8);
        repeat (5) @(negedge clk);
        spi_bus.ncs = 1'b1;
        repeat (12) @(negedge clk);
        for (int r = 0; r < 5; r++) begin
            chk_cnt++;
            if (obs[r] !== 8'h00) $display("FAIL rstmid_reg%0d got %h want 00", r, obs[r]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (strobe_cnt - base !== 0) $display("FAIL rstmid_strobe got %0d want 0", strobe_cnt - base);
        else pass_cnt++;
        send_frame(16'h8355, 16, 12);
        chk_cnt++;
        if (en_reg_pwm_15_8 !== 8'h55) $display("FAIL rstmid_good got %h want 55", en_reg_pwm_15_8);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int base;
        logic [15:0] words [5];
        base = strobe_cnt;
        words = '{16'h8011, 16'h8122, 16'h8233, 16'h8344, 16'h84E7};
        // Gap of 10 clk is one SCLK period with nCS high.
        for (int w = 0; w < 5; w++) send_frame(words[w], 16, 10);
        repeat (10) @(negedge clk);
        exp_regs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hE7};
        for (int r = 0; r < 5; r++) begin
            chk_cnt++;
            if (obs[r] !== exp_regs[r])
                $display("FAIL b2b_reg%0d got %h want %h", r, obs[r], exp_regs[r]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (strobe_cnt - base !== 5) $display("FAIL b2b_strobe got %0d want 5", strobe_cnt - base);
        else pass_cnt++;
    endtask

    initial begin
        spi_bus.sclk = 1'b0;
        spi_bus.copi = 1'b0;
        spi_bus.ncs  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_write();
        test_dropped();
        test_length();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
